// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Conditions a raw, bouncy, asynchronous pin into a clean level in the clk
// domain. The pin passes through a 2-FF synchroniser. A 4-state FSM plus a
// stability counter then accepts a new level only after DEBOUNCE_CYCLES
// consecutive synchronised samples at that value. Every transition that is
// abandoned part-way is counted in a saturating diagnostic counter.
//
// Ports:
//   clk          - system clock
//   rst_n        - asynchronous active-low reset
//   raw_i        - raw pin, asynchronous to clk
//   level_o      - debounced level, driven straight from a flop
//   bounce_cnt_o - saturating count of aborted transitions, registered
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BOUNCE_CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    raw_i,
  output logic                    level_o,
  output logic [BOUNCE_CNT_W-1:0] bounce_cnt_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  // The counter only ever needs to reach DEBOUNCE_CYCLES-1: acceptance
  // happens on the sample that arrives while it holds that value.
  localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]        CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1);
  localparam logic [BOUNCE_CNT_W-1:0] BOUNCE_MAX = {BOUNCE_CNT_W{1'b1}};
  localparam logic [BOUNCE_CNT_W-1:0] BOUNCE_ONE = BOUNCE_CNT_W'(1);
  localparam logic [BOUNCE_CNT_W-1:0] BOUNCE_ZERO = BOUNCE_CNT_W'(0);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } state_e;

  logic                    sync1_q;
  logic                    sync_q;
  state_e                  state_q;
  logic [CNT_W-1:0]        stab_cnt_q;
  logic                    level_q;
  logic [BOUNCE_CNT_W-1:0] bounce_cnt_q;

  // Saturating increment: the diagnostic counter sticks at all-ones.
  function automatic logic [BOUNCE_CNT_W-1:0] sat_inc(
    input logic [BOUNCE_CNT_W-1:0] v
  );
    if (v == BOUNCE_MAX) begin
      return v;
    end else begin
      return v + BOUNCE_ONE;
    end
  endfunction

  // Two-stage synchroniser; only sync_q is ever looked at downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync_q  <= sync1_q;
    end
  end

  // Debounce FSM with stability counter, registered level and bounce counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= STABLE_LOW;
      stab_cnt_q   <= CNT_ZERO;
      level_q      <= 1'b0;
      bounce_cnt_q <= BOUNCE_ZERO;
    end else begin
      case (state_q)
        STABLE_LOW: begin
          level_q <= 1'b0;
          if (sync_q) begin
            state_q    <= WAIT_HIGH;
            stab_cnt_q <= CNT_ONE;
          end else begin
            stab_cnt_q <= CNT_ZERO;
          end
        end
        WAIT_HIGH: begin
          if (!sync_q) begin
            // Fell back before the high level proved stable: a bounce.
            state_q      <= STABLE_LOW;
            stab_cnt_q   <= CNT_ZERO;
            bounce_cnt_q <= sat_inc(bounce_cnt_q);
          end else if (stab_cnt_q == CNT_LAST) begin
            state_q    <= STABLE_HIGH;
            level_q    <= 1'b1;
            stab_cnt_q <= CNT_ZERO;
          end else begin
            stab_cnt_q <= stab_cnt_q + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          level_q <= 1'b1;
          if (!sync_q) begin
            state_q    <= WAIT_LOW;
            stab_cnt_q <= CNT_ONE;
          end else begin
            stab_cnt_q <= CNT_ZERO;
          end
        end
        WAIT_LOW: begin
          if (sync_q) begin
            // Rose again before the low level proved stable: a bounce.
            state_q      <= STABLE_HIGH;
            stab_cnt_q   <= CNT_ZERO;
            bounce_cnt_q <= sat_inc(bounce_cnt_q);
          end else if (stab_cnt_q == CNT_LAST) begin
            state_q    <= STABLE_LOW;
            level_q    <= 1'b0;
            stab_cnt_q <= CNT_ZERO;
          end else begin
            stab_cnt_q <= stab_cnt_q + CNT_ONE;
          end
        end
        default: begin
          // Unreachable encoding: fall back to the safe idle-low state.
          state_q    <= STABLE_LOW;
          level_q    <= 1'b0;
          stab_cnt_q <= CNT_ZERO;
        end
      endcase
    end
  end

  assign level_o      = level_q;
  assign bounce_cnt_o = bounce_cnt_q;

endmodule
